// File: rtl/pwm_duty_meter_pkg.sv
// Shared constants for the PWM pulse generator and its duty meter.
//   FRAME_BITS_DEF   : width of the generator's PWM counter; one frame is
//                      2^FRAME_BITS_DEF sysclk cycles.
//   STUCK_FRAMES_DEF : consecutive all-high / all-low frames that raise a
//                      stuck flag.
//   full_scale()     : high-cycle count of a 100% frame for a given width.
package pwm_duty_meter_pkg;

  localparam int FRAME_BITS_DEF   = 6;
  localparam int FULL_SCALE       = 1 << FRAME_BITS_DEF;
  localparam int STUCK_FRAMES_DEF = 16;

  function automatic int full_scale(input int frame_bits);
    return 1 << frame_bits;
  endfunction

endpackage

// File: rtl/pwm_duty_meter_sync.sv
// Input synchroniser for the (possibly asynchronous) PWM pulse line.
//   clk_i  : sampling clock
//   rst_ni : asynchronous active-low reset, clears every stage to 0
//   d_i    : raw input
//   q_o    : d_i delayed by STAGES clock cycles
// STAGES must be at least 2.
module pulse_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pwm_duty_meter.sv
// PWM duty meter: measures high-cycle count and rising-edge count of the
// synchronised pulse over fixed frames of 2^FRAME_BITS cycles, and flags
// sustained all-high / all-low operation.
//   sysclk     : system clock
//   rst_n      : asynchronous active-low reset
//   pulse_in   : PWM pulse, may be asynchronous
//   enable     : measurement enable (IDLE when 0, MEASURE when 1)
//   duty_out   : high cycles in the last completed frame, 0..2^FRAME_BITS
//   rise_out   : rising edges in the last completed frame
//   duty_valid : one-cycle strobe when duty_out / rise_out update
//   stuck_hi   : last STUCK_FRAMES frames were each 100% high
//   stuck_lo   : last STUCK_FRAMES frames were each 0% high
module pwm_duty_meter
  import pwm_duty_meter_pkg::*;
#(
  parameter int FRAME_BITS   = FRAME_BITS_DEF,
  parameter int SYNC_STAGES  = 2,
  parameter int STUCK_FRAMES = STUCK_FRAMES_DEF
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  input  logic                  pulse_in,
  input  logic                  enable,
  output logic [FRAME_BITS:0]   duty_out,
  output logic [FRAME_BITS-1:0] rise_out,
  output logic                  duty_valid,
  output logic                  stuck_hi,
  output logic                  stuck_lo
);

  localparam logic [FRAME_BITS:0] FULL_V  = (FRAME_BITS+1)'(full_scale(FRAME_BITS));
  localparam logic [7:0]          STUCK_V = 8'(STUCK_FRAMES);

  logic s;

  pulse_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (sysclk),
    .rst_ni (rst_n),
    .d_i    (pulse_in),
    .q_o    (s)
  );

  logic [FRAME_BITS-1:0] frame_cnt_q, frame_cnt_d;
  logic [FRAME_BITS:0]   high_cnt_q, high_cnt_d;
  logic [FRAME_BITS-1:0] rise_cnt_q, rise_cnt_d;
  logic                  prev_q, prev_d;
  logic [7:0]            run_hi_q, run_hi_d;
  logic [7:0]            run_lo_q, run_lo_d;
  logic [FRAME_BITS:0]   duty_q, duty_d;
  logic [FRAME_BITS-1:0] rise_q, rise_d;
  logic                  valid_q, valid_d;
  logic                  stuck_hi_q, stuck_hi_d;
  logic                  stuck_lo_q, stuck_lo_d;

  logic                  rising;
  logic [FRAME_BITS:0]   duty_frame;
  logic [FRAME_BITS-1:0] rise_frame;

  assign rising     = s & ~prev_q;
  // Totals include the current (last) sample so nothing is lost when the
  // accumulators restart on the same edge.
  assign duty_frame = high_cnt_q + (FRAME_BITS+1)'(s);
  assign rise_frame = rise_cnt_q + FRAME_BITS'(rising);

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    high_cnt_d  = high_cnt_q;
    rise_cnt_d  = rise_cnt_q;
    run_hi_d    = run_hi_q;
    run_lo_d    = run_lo_q;
    duty_d      = duty_q;
    rise_d      = rise_q;
    valid_d     = 1'b0;
    stuck_hi_d  = stuck_hi_q;
    stuck_lo_d  = stuck_lo_q;
    // prev_sample tracks s even while idle so the first sample after enable
    // is compared against the real previous level.
    prev_d      = s;

    if (!enable) begin
      frame_cnt_d = '0;
      high_cnt_d  = '0;
      rise_cnt_d  = '0;
      run_hi_d    = '0;
      run_lo_d    = '0;
    end else begin
      frame_cnt_d = frame_cnt_q + 1'b1;
      if (frame_cnt_q == '1) begin
        duty_d     = duty_frame;
        rise_d     = rise_frame;
        valid_d    = 1'b1;
        high_cnt_d = '0;
        rise_cnt_d = '0;
        if (duty_frame == FULL_V) begin
          run_lo_d = '0;
          run_hi_d = (run_hi_q == STUCK_V) ? run_hi_q : run_hi_q + 8'd1;
        end else if (duty_frame == '0) begin
          run_hi_d = '0;
          run_lo_d = (run_lo_q == STUCK_V) ? run_lo_q : run_lo_q + 8'd1;
        end else begin
          run_hi_d = '0;
          run_lo_d = '0;
        end
        stuck_hi_d = (run_hi_d == STUCK_V);
        stuck_lo_d = (run_lo_d == STUCK_V);
      end else begin
        high_cnt_d = duty_frame;
        rise_cnt_d = rise_frame;
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      high_cnt_q  <= '0;
      rise_cnt_q  <= '0;
      prev_q      <= 1'b0;
      run_hi_q    <= '0;
      run_lo_q    <= '0;
      duty_q      <= '0;
      rise_q      <= '0;
      valid_q     <= 1'b0;
      stuck_hi_q  <= 1'b0;
      stuck_lo_q  <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      high_cnt_q  <= high_cnt_d;
      rise_cnt_q  <= rise_cnt_d;
      prev_q      <= prev_d;
      run_hi_q    <= run_hi_d;
      run_lo_q    <= run_lo_d;
      duty_q      <= duty_d;
      rise_q      <= rise_d;
      valid_q     <= valid_d;
      stuck_hi_q  <= stuck_hi_d;
      stuck_lo_q  <= stuck_lo_d;
    end
  end

  assign duty_out   = duty_q;
  assign rise_out   = rise_q;
  assign duty_valid = valid_q;
  assign stuck_hi   = stuck_hi_q;
  assign stuck_lo   = stuck_lo_q;

endmodule

// File: doc/pwm_duty_meter.md
Name: pwm_duty_meter

Overview:
Downstream monitor for the square-modulated PWM pulse generator. It samples the generator's Pulse line on sysclk and measures, per fixed frame of 2^FRAME_BITS cycles, the high-cycle count (duty) and the number of rising edges. It flags sustained stuck-high or stuck-low conditions, such as the full-on and full-off halves of the modulation, for status LEDs and self-check logic.

Parameters:
FRAME_BITS, 6, frame length is 2^FRAME_BITS cycles; matches the generator's 6-bit PWM counter.
SYNC_STAGES, 2, flops in the input synchroniser; minimum 2.
STUCK_FRAMES, 16, consecutive all-high or all-low frames needed to raise a stuck flag; range 1..255.

Ports:
sysclk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
pulse_in  input  1  PWM pulse from the generator; may be asynchronous.
enable  input  1  measurement enable; synchronous to sysclk.
duty_out  output  FRAME_BITS+1  high-cycle count of the last completed frame, range 0..2^FRAME_BITS.
rise_out  output  FRAME_BITS  rising edges in the last completed frame.
duty_valid  output  1  one-cycle strobe: duty_out and rise_out were updated this cycle.
stuck_hi  output  1  last STUCK_FRAMES frames were each 100% high.
stuck_lo  output  1  last STUCK_FRAMES frames were each 0% high.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs are 0; synchroniser flops, frame_cnt, high_cnt, rise_cnt, prev_sample, and both run counters are 0.
- Synchroniser: s = pulse_in delayed by SYNC_STAGES cycles; only s is used downstream.
- enable=0:
  - frame_cnt, high_cnt, rise_cnt, and both run counters are held at 0.
  - duty_valid=0; duty_out, rise_out, and the stuck flags hold their values.
  - The synchroniser and prev_sample keep running.
- enable=1: frame_cnt increments each cycle and wraps from 2^FRAME_BITS-1 to 0.
  - The cycle with frame_cnt=0 is the frame's first sample.
- Per cycle while enabled:
  - high_cnt accumulates s.
  - rise_cnt increments when s=1 and prev_sample=0.
  - prev_sample <= s every cycle, enabled or not. The first sample of a frame is therefore compared against the last sample of the previous frame (or the pre-enable value).
- Frame end (frame_cnt = 2^FRAME_BITS-1, enabled):
  - Next edge: duty_out <= high_cnt + s; rise_out <= rise_cnt + rising(s); duty_valid <= 1 for exactly one cycle.
  - The same edge restarts high_cnt and rise_cnt at 0. No sample is lost or double-counted.
- Latency: frame boundary sample to duty_valid is 1 cycle, plus SYNC_STAGES cycles from the pulse_in pin.
- Widths: duty accumulator is FRAME_BITS+1 bits, so 2^FRAME_BITS is representable. rise_cnt cannot exceed 2^(FRAME_BITS-1) and needs no saturation.
- Stuck tracking, evaluated on each completed frame:
  - Full frame (duty = 2^FRAME_BITS): run_hi increments, saturating at STUCK_FRAMES; run_lo clears.
  - Empty frame (duty = 0): run_lo increments, saturating at STUCK_FRAMES; run_hi clears.
  - Any other duty: both run counters clear.
  - stuck_hi = (run_hi == STUCK_FRAMES); stuck_lo likewise. Flags are registered and update in the same cycle as duty_valid.
- enable dropping mid-frame: the partial frame is discarded with no duty_valid. The next enable starts a fresh frame at frame_cnt=0, and both run counters restart from 0.
- State is implicit: IDLE (enable=0) and MEASURE (enable=1); no further FSM.

Decomposition:
- Shared package: FRAME_BITS default, full-scale constant 2^FRAME_BITS, and the STUCK_FRAMES default, shared with the pulse generator.
- One sub-module, pulse_sync: SYNC_STAGES flop chain, reset to 0. The remainder stays flat in pwm_duty_meter.

Test Plan:
1. Reset release with pulse_in=1 constant and enable=1 from the first cycle -> first frame duty_out=62 (two synchroniser zeros), rise_out=1; second frame duty_out=64, rise_out=0.
2. Drive the generator's pattern: 32 frames full, then 32 frames empty, STUCK_FRAMES=16 -> stuck_hi rises with the 16th full-frame strobe and clears on the first empty frame; stuck_lo rises on the 16th empty frame.
3. pulse_in toggles every cycle -> every frame duty_out=32, rise_out=32, duty_valid exactly every 64 cycles, both stuck flags 0.
4. 25% PWM (high for frame_cnt 0..15, period 64) -> duty_out=16, rise_out=1 each frame.
5. enable dropped at frame_cnt=40 for 10 cycles, then re-asserted -> no duty_valid for the aborted frame; next strobe exactly 64 cycles after re-enable with a full-frame count; run counters restarted.
6. rst_n pulsed low mid-frame for 1 cycle (asynchronous, between clock edges) -> all outputs 0 immediately; measurement resumes from frame_cnt=0 after release.
